// File: rtl/linha_pkg.sv
// Shared definitions for the bottling line: master FSM state encoding, route step codes and
// conveyor destination codes (the destination codes are also used by the conveyor sensor mux).
package linha_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StReq    = 3'd1,
    StRel    = 3'd2,
    StAlarme = 3'd3,
    StErro   = 3'd4
  } estado_e;

  // Route steps for one bottle, walked in ascending order
  localparam logic [2:0] PASSO_MOVER_ENCH  = 3'd0;
  localparam logic [2:0] PASSO_ENCHER      = 3'd1;
  localparam logic [2:0] PASSO_MOVER_VED   = 3'd2;
  localparam logic [2:0] PASSO_VEDAR       = 3'd3;
  localparam logic [2:0] PASSO_MOVER_SAIDA = 3'd4;

  // Conveyor destinations
  localparam logic [1:0] DEST_ENCH  = 2'd0;
  localparam logic [1:0] DEST_VED   = 2'd1;
  localparam logic [1:0] DEST_SAIDA = 2'd2;

  function automatic logic passo_e_mover(logic [2:0] passo);
    return (passo == PASSO_MOVER_ENCH) || (passo == PASSO_MOVER_VED) ||
           (passo == PASSO_MOVER_SAIDA);
  endfunction

  function automatic logic [1:0] destino_do_passo(logic [2:0] passo);
    logic [1:0] dest;
    case (passo)
      PASSO_MOVER_VED:   dest = DEST_VED;
      PASSO_MOVER_SAIDA: dest = DEST_SAIDA;
      default:           dest = DEST_ENCH;
    endcase
    return dest;
  endfunction

endpackage

// File: rtl/hs_watchdog.sv
// Handshake watchdog: counts cycles while enabled, restarts on clear, and flags expiry once
// Limit cycles have elapsed since the last clear. Saturates at expiry.
module hs_watchdog #(
  parameter int unsigned Limit = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [31:0] cnt_q, cnt_d;

  // Expiry is flagged one cycle early so the owner leaves on the Limit-th edge
  assign expired_o = (cnt_q >= (Limit - 32'd1));

  // Next count: clear wins over counting; hold once expired
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fsm_mestre.sv
// Master sequencer for the bottling line. Initiator of the four-phase command/completion
// handshake towards the conveyor, filler and capper. Route per bottle: move to filler, fill,
// move to capper, cap, move to exit. Optional handshake watchdog under FSM_MESTRE_TIMEOUT_EN.
module fsm_mestre
  import linha_pkg::*;
#(
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             alarme_rolha,
  input  logic             esteira_concluida,
  input  logic             enchimento_concluido,
  input  logic             vedacao_concluida,
  output logic             cmd_mover,
  output logic [1:0]       destino_sel,
  output logic             cmd_encher,
  output logic             cmd_vedar,
  output logic [CNT_W-1:0] garrafas_cnt,
  output logic             ocupado,
  output logic             erro_timeout
);

  estado_e          state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmd_mover_q, cmd_mover_d;
  logic             cmd_encher_q, cmd_encher_d;
  logic             cmd_vedar_q, cmd_vedar_d;
  logic [1:0]       destino_q, destino_d;
  logic             ocupado_q, ocupado_d;
  logic             erro_q, erro_d;
  logic             done_sel;
  logic             expirado;

`ifdef FSM_MESTRE_TIMEOUT_EN
  logic wd_clr, wd_en;

  assign wd_en  = (state_q == StReq) || (state_q == StRel);
  assign wd_clr = ((state_d == StReq) || (state_d == StRel)) && (state_d != state_q);

  hs_watchdog #(
    .Limit (TIMEOUT_CYCLES)
  ) u_hs_watchdog (
    .clk_i     (clk),
    .rst_i     (reset),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (expirado)
  );
`else
  // No watchdog: never expires (the term only keeps TIMEOUT_CYCLES referenced)
  assign expirado = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // Completion input of the slave addressed by the current step
  always_comb begin
    done_sel = esteira_concluida;
    case (step_q)
      PASSO_ENCHER: done_sel = enchimento_concluido;
      PASSO_VEDAR:  done_sel = vedacao_concluida;
      default:      done_sel = esteira_concluida;
    endcase
  end

  // Next state, step and bottle count
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start && !alarme_rolha) begin
          state_d = StReq;
          step_d  = PASSO_MOVER_ENCH;
        end
      end
      StReq: begin
        if (expirado) begin
          state_d = StErro;
        end else if (alarme_rolha) begin
          state_d = StAlarme;
        end else if (done_sel) begin
          state_d = StRel;
        end
      end
      StRel: begin
        if (expirado) begin
          state_d = StErro;
        end else if (!done_sel) begin
          if (step_q == PASSO_MOVER_SAIDA) begin
            state_d = StIdle;
            step_d  = PASSO_MOVER_ENCH;
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            state_d = StReq;
            step_d  = step_q + 3'd1;
          end
        end
      end
      StAlarme: begin
        if (!alarme_rolha && !esteira_concluida && !enchimento_concluido &&
            !vedacao_concluida) begin
          state_d = StIdle;
          step_d  = PASSO_MOVER_ENCH;
        end
      end
      StErro: begin
        state_d = StErro;
      end
      default: begin
        state_d = StIdle;
        step_d  = PASSO_MOVER_ENCH;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs track the state register
  always_comb begin
    cmd_mover_d  = (state_d == StReq) && passo_e_mover(step_d);
    cmd_encher_d = (state_d == StReq) && (step_d == PASSO_ENCHER);
    cmd_vedar_d  = (state_d == StReq) && (step_d == PASSO_VEDAR);
    ocupado_d    = (state_d != StIdle);
    erro_d       = (state_d == StErro);
    destino_d    = destino_q;
    if ((state_d == StIdle) || (state_d == StAlarme) || (state_d == StErro)) begin
      destino_d = DEST_ENCH;
    end else if ((state_d == StReq) && passo_e_mover(step_d)) begin
      destino_d = destino_do_passo(step_d);
    end
  end

  // State, step, counter and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      step_q       <= PASSO_MOVER_ENCH;
      cnt_q        <= '0;
      cmd_mover_q  <= 1'b0;
      cmd_encher_q <= 1'b0;
      cmd_vedar_q  <= 1'b0;
      destino_q    <= DEST_ENCH;
      ocupado_q    <= 1'b0;
      erro_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      cnt_q        <= cnt_d;
      cmd_mover_q  <= cmd_mover_d;
      cmd_encher_q <= cmd_encher_d;
      cmd_vedar_q  <= cmd_vedar_d;
      destino_q    <= destino_d;
      ocupado_q    <= ocupado_d;
      erro_q       <= erro_d;
    end
  end

  assign cmd_mover    = cmd_mover_q;
  assign cmd_encher   = cmd_encher_q;
  assign cmd_vedar    = cmd_vedar_q;
  assign destino_sel  = destino_q;
  assign garrafas_cnt = cnt_q;
  assign ocupado      = ocupado_q;
  assign erro_timeout = erro_q;

endmodule

// File: tb/tb_fsm_mestre.sv
// Bench for fsm_mestre: slave models with random answer latency, a per-bottle expected route
// and a modular bottle count. Checks FSM_MESTRE_TIMEOUT_EN behaviour when that macro is set.
module tb_fsm_mestre;

  localparam int unsigned CW = 2;
  localparam int unsigned TO = 20;

  logic          clk = 1'b0;
  logic          reset, start, alarme_rolha;
  logic          esteira_concluida, enchimento_concluido, vedacao_concluida;
  logic          cmd_mover, cmd_encher, cmd_vedar;
  logic [1:0]    destino_sel;
  logic [CW-1:0] garrafas_cnt;
  logic          ocupado, erro_timeout;

  fsm_mestre #(
    .CNT_W          (CW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .alarme_rolha         (alarme_rolha),
    .esteira_concluida    (esteira_concluida),
    .enchimento_concluido (enchimento_concluido),
    .vedacao_concluida    (vedacao_concluida),
    .cmd_mover            (cmd_mover),
    .destino_sel          (destino_sel),
    .cmd_encher           (cmd_encher),
    .cmd_vedar            (cmd_vedar),
    .garrafas_cnt         (garrafas_cnt),
    .ocupado              (ocupado),
    .erro_timeout         (erro_timeout)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ev[$];          // observed command rises: 2*dest for mover, 1 fill, 3 cap
  int exp_cnt = 0;    // bottles finished since last reset
  logic pm = 0, pe = 0, pv = 0;
  int hm = 0, he = 0, hv = 0;
  int dm = 0, de = 0, dv = 0;
  bit mute_fill = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One clock: sample just after the edge, record command rises, update slave answers
  task automatic tick();
    @(posedge clk);
    #1;
    if (cmd_mover && !pm) ev.push_back(2 * int'(destino_sel));
    if (cmd_encher && !pe) ev.push_back(1);
    if (cmd_vedar && !pv) ev.push_back(3);
    pm = cmd_mover;
    pe = cmd_encher;
    pv = cmd_vedar;
    hm = cmd_mover ? hm + 1 : 0;
    he = cmd_encher ? he + 1 : 0;
    hv = cmd_vedar ? hv + 1 : 0;
    esteira_concluida    = cmd_mover && (hm > dm);
    enchimento_concluido = cmd_encher && (he > de) && !mute_fill;
    vedacao_concluida    = cmd_vedar && (hv > dv);
  endtask

  task automatic check_quiet(input string tag);
    chk($sformatf("%s_mover", tag), cmd_mover, 0);
    chk($sformatf("%s_encher", tag), cmd_encher, 0);
    chk($sformatf("%s_vedar", tag), cmd_vedar, 0);
    chk($sformatf("%s_dest", tag), destino_sel, 0);
    chk($sformatf("%s_ocupado", tag), ocupado, 0);
    chk($sformatf("%s_erro", tag), erro_timeout, 0);
  endtask

  // One start pulse, wait for IDLE, check route and count; returns cycles from start to IDLE
  task automatic run_bottle(input string tag, input bit rnd, output int n);
    dm = rnd ? int'($urandom_range(0, 3)) : 0;
    de = rnd ? int'($urandom_range(0, 3)) : 0;
    dv = rnd ? int'($urandom_range(0, 3)) : 0;
    ev.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (ocupado && n < 300) begin
      tick();
      n++;
    end
    exp_cnt++;
    chk($sformatf("%s_idle", tag), ocupado, 0);
    chk($sformatf("%s_cnt", tag), garrafas_cnt, exp_cnt % (1 << CW));
    chk($sformatf("%s_nev", tag), ev.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("%s_ev%0d", tag, i), (i < ev.size()) ? ev[i] : -1, i);
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    alarme_rolha = 1'b0;
    esteira_concluida = 1'b0;
    enchimento_concluido = 1'b0;
    vedacao_concluida = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_quiet("reset");
    chk("reset_cnt", garrafas_cnt, 0);

    // Instant slaves, single bottle: route, count and 11-cycle length
    run_bottle("instant", 1'b0, n);
    chk("instant_cycles", n, 11);

    // Alarm rising together with capper completion in step 3 REQ
    dm = 0; de = 0; dv = 0;
    ev.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!cmd_vedar && n < 100) begin
      tick();
      n++;
    end
    chk("alarm_reach_vedar", cmd_vedar, 1);
    alarme_rolha = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("alarm_hold%0d_vedar", i), cmd_vedar, 0);
      chk($sformatf("alarm_hold%0d_mover", i), cmd_mover, 0);
      chk($sformatf("alarm_hold%0d_ocupado", i), ocupado, 1);
    end
    alarme_rolha = 1'b0;
    tick();
    chk("alarm_exit_idle", ocupado, 0);
    chk("alarm_cnt_kept", garrafas_cnt, exp_cnt % (1 << CW));
    chk("alarm_nev", ev.size(), 4);

    // Start blocked while the alarm is active
    alarme_rolha = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("alarm_start%0d_ocupado", i), ocupado, 0);
      chk($sformatf("alarm_start%0d_mover", i), cmd_mover, 0);
    end
    start = 1'b0;
    alarme_rolha = 1'b0;
    tick();

    // start held high: back-to-back bottles, 11 cycles each
    ev.delete();
    dm = 0; de = 0; dv = 0;
    start = 1'b1;
    repeat (33) tick();
    start = 1'b0;
    exp_cnt += 3;
    chk("held_idle", ocupado, 0);
    chk("held_cnt", garrafas_cnt, exp_cnt % (1 << CW));
    chk("held_nev", ev.size(), 15);
    tick();
    chk("held_stays_idle", ocupado, 0);

    // Reset during step 2 REQ
    ev.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(cmd_mover && destino_sel == 2'd1) && n < 100) begin
      tick();
      n++;
    end
    chk("rst_reach_step2", destino_sel, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cnt = 0;
    check_quiet("rst_mid");
    chk("rst_mid_cnt", garrafas_cnt, 0);
    tick();
    run_bottle("after_rst", 1'b0, n);

    // Counter wrap over five random-latency bottles: 1, 2, 3, 0, 1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cnt = 0;
    tick();
    for (int k = 0; k < 5; k++) begin
      run_bottle($sformatf("wrap%0d", k), 1'b1, n);
    end

    // Filler never answers
    dm = 0; de = 0; dv = 0;
    mute_fill = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!cmd_encher && n < 50) begin
      tick();
      n++;
    end
    chk("stall_encher_up", cmd_encher, 1);
    repeat (TO - 1) tick();
    chk("stall_encher_still", cmd_encher, 1);
    chk("stall_no_err_yet", erro_timeout, 0);
`ifdef FSM_MESTRE_TIMEOUT_EN
    tick();
    chk("to_erro", erro_timeout, 1);
    chk("to_encher_low", cmd_encher, 0);
    chk("to_ocupado", ocupado, 1);
    chk("to_dest", destino_sel, 0);
    repeat (5) tick();
    chk("to_erro_held", erro_timeout, 1);
`else
    repeat (40) tick();
    chk("noto_encher_high", cmd_encher, 1);
    chk("noto_no_err", erro_timeout, 0);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mute_fill = 1'b0;
    check_quiet("final_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_mestre.md
# fsm_mestre

Master sequencer for the bottling line. It is the initiator side of the four-phase command/completion handshake that the conveyor, filler and capper FSMs answer. For each bottle it walks a fixed route: move to the filler, fill, move to the capper, cap, move to the exit. Each step is one handshake. It counts finished bottles, aborts on the cork-shortage alarm, and optionally detects a stalled slave.

## Interface
Parameters:
- `CNT_W`, 8: width of the finished-bottle counter.
- `TIMEOUT_CYCLES`, 500_000_000: watchdog limit per handshake phase (10 s at 50 MHz). Used only with `FSM_MESTRE_TIMEOUT_EN`.

Ports:
- `clk` in 1: 50 MHz system clock; single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: level request to process one bottle; sampled in IDLE only.
- `alarme_rolha` in 1: cork-shortage alarm, level.
- `esteira_concluida` in 1: conveyor completion (slave `tarefa_concluida`).
- `enchimento_concluido` in 1: filler completion.
- `vedacao_concluida` in 1: capper completion.
- `cmd_mover` out 1: conveyor request.
- `destino_sel` out 2: conveyor destination. 0 = filler (SW0), 1 = capper (SW2), 2 = exit (SW4).
- `cmd_encher` out 1: filler request.
- `cmd_vedar` out 1: capper request.
- `garrafas_cnt` out CNT_W: finished-bottle count.
- `ocupado` out 1: high in any state other than IDLE.
- `erro_timeout` out 1: watchdog fault flag.

## Operation
- Moore machine. Every output is decoded from the state register and step register only; there are no input-to-output paths.
- States:
  - IDLE
  - REQ: command high, waiting for done = 1.
  - REL: command low, waiting for done = 0.
  - ALARME
  - ERRO
- Step register, 3 bits, values 0–4:
  - 0: mover, destination 0
  - 1: encher
  - 2: mover, destination 1
  - 3: vedar
  - 4: mover, destination 2
- Active done input is muxed by step: steps 0, 2, 4 use `esteira_concluida`; step 1 uses `enchimento_concluido`; step 3 uses `vedacao_concluida`.
- IDLE:
  - `start` = 1 and `alarme_rolha` = 0 → REQ, step 0.
  - Otherwise stay in IDLE.
- REQ: the command for the current step is high and `destino_sel` is driven.
  - `alarme_rolha` = 1 → ALARME. Alarm has priority over done.
  - Otherwise, done = 1 → REL.
- REL: all commands are low; `destino_sel` holds its last value.
  - done = 0 and step < 4 → REQ, step + 1.
  - done = 0 and step = 4 → IDLE, and `garrafas_cnt` increments.
  - `alarme_rolha` is ignored in REL.
- ALARME: all commands are low and the bottle is aborted, not counted.
  - Leave when `alarme_rolha` = 0 and all three done inputs are 0 → IDLE.
- ERRO: all commands are low and `erro_timeout` = 1.
  - Exit only by `reset`.
- `garrafas_cnt` wraps from 2^CNT_W−1 to 0.
- `start` held high continuously auto-restarts a new bottle from IDLE. `start` outside IDLE is ignored.
- `destino_sel` is 0 in IDLE, ALARME and ERRO.

## Timing
- Reset values: state IDLE, step 0, all commands 0, `destino_sel` 0, `garrafas_cnt` 0, `ocupado` 0, `erro_timeout` 0.
- `reset` mid-operation clears everything at the next edge. Slaves see their command drop and return to their own idle state.
- `start` sampled high at edge N → `cmd_mover` = 1 after edge N.
- done sampled high at edge N → command low after edge N. Minimum command width is 1 cycle.
- Minimum bottle: 5 handshakes of 2 cycles each plus 1 IDLE cycle, so 11 cycles from `start` to the next IDLE with instant slaves.
- The counter updates on the same edge that enters IDLE from step 4.
- A done already high on entry to REQ is accepted on the first REQ cycle.

## Configuration
- `FSM_MESTRE_TIMEOUT_EN` defined:
  - A cycle counter clears on every entry to REQ or REL and counts while in either state.
  - Reaching `TIMEOUT_CYCLES` moves to ERRO on the next edge.
  - The counter is 32 bits wide.
- Undefined:
  - No counter is instantiated.
  - `erro_timeout` is tied to 0.
  - ERRO is unreachable; REQ/REL wait indefinitely.

## Structure
- Shared package `linha_pkg`:
  - State encoding: IDLE = 0, REQ = 1, REL = 2, ALARME = 3, ERRO = 4.
  - Step codes.
  - Destination codes `DEST_ENCH` = 0, `DEST_VED` = 1, `DEST_SAIDA` = 2.
- These destination codes are shared with the conveyor sensor mux.
- One sub-module, `hs_watchdog`: clear/enable/expire counter, instantiated only under the macro.

## Test plan
- Instant slaves (done = command delayed 1 cycle), one `start` pulse:
  - `cmd_mover`(0), `cmd_encher`, `cmd_mover`(1), `cmd_vedar`, `cmd_mover`(2) each seen exactly once, in order.
  - `garrafas_cnt` 0 → 1.
  - Back in IDLE 11 cycles after `start`.
- Alarm in step 3 REQ, with alarm and `vedacao_concluida` rising in the same cycle:
  - ALARME is entered and `cmd_vedar` drops.
  - After alarm = 0 and done = 0: IDLE, count unchanged.
  - `start` with `alarme_rolha` = 1 in IDLE → stays in IDLE, `ocupado` = 0.
- With `CNT_W` = 2, run 5 bottles → `garrafas_cnt` sequence 1, 2, 3, 0, 1.
- `reset` pulsed during step 2 REQ → next cycle all outputs 0 and count 0. A following `start` restarts at step 0.
- Macro on, `TIMEOUT_CYCLES` = 20, filler never answers:
  - ERRO 20 cycles after `cmd_encher` rises, `erro_timeout` = 1 until reset.
  - Macro off, same stimulus → `cmd_encher` stays high indefinitely.
